// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line.
// Hits answer one cycle after the request. Misses fetch the word from the memory controller.
// A branch flush during a miss drains the outstanding read and holds one new request for replay.
// Optional next-line prefetch is compiled in when ICACHE_PREFETCH_EN is defined.
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_to_icache_en_in,
  input  logic [ADDR_W-1:0] if_a_in,
  output logic              icache_to_if_en_out,
  output logic [31:0]       if_d_out,
  output logic              icache_to_mc_en_out,
  output logic [ADDR_W-1:0] icache_a_out,
  input  logic              mc_to_icache_en_in,
  input  logic [31:0]       mc_d_in,
  input  logic              clear_branch_in
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
  localparam int WA_W  = ADDR_W - 2;

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, MISS, DRAIN, PREFETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;
`endif

  state_t state, next_state, after_fill;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES];

  // Word addresses (byte offset dropped) for the line being filled and the held request
  logic [WA_W-1:0]   miss_w, next_miss_w, pend_w, next_pend_w;
  logic [ADDR_W-1:0] mc_a, next_mc_a;
  logic              pend_v, next_pend_v, resp_en, next_resp_en, mc_en, next_mc_en;
  logic [31:0]       resp_d, next_resp_d;
  logic              fill_we;

  logic              lk_req, lk_hit;
  logic [WA_W-1:0]   lk_w;
  logic [INDEX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0]  lk_tag, fill_tag;
  logic              unused_byte_offset;

  // A replayed request takes priority over the fetch port; the protocol keeps them apart
  assign lk_req   = if_to_icache_en_in | pend_v;
  assign lk_w     = pend_v ? pend_w : if_a_in[ADDR_W-1:2];
  assign lk_idx   = lk_w[INDEX_BITS-1:0];
  assign lk_tag   = lk_w[WA_W-1:INDEX_BITS];
  assign lk_hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign fill_idx = miss_w[INDEX_BITS-1:0];
  assign fill_tag = miss_w[WA_W-1:INDEX_BITS];
  assign unused_byte_offset = ^if_a_in[1:0];

`ifdef ICACHE_PREFETCH_EN
  logic [WA_W-1:0]       pf_w;
  logic [INDEX_BITS-1:0] pf_idx;
  logic                  pf_need;
  // Next sequential word wraps naturally at the top of the address space
  assign pf_w       = miss_w + WA_W'(1);
  assign pf_idx     = pf_w[INDEX_BITS-1:0];
  assign pf_need    = !valid[pf_idx] || (tags[pf_idx] != pf_w[WA_W-1:INDEX_BITS]);
  assign after_fill = pf_need ? PREFETCH : IDLE;
`else
  assign after_fill = IDLE;
`endif

  // Next-state and next-output logic for the miss/drain controller
  always_comb begin
    next_state   = state;
    next_miss_w  = miss_w;
    next_pend_v  = pend_v;
    next_pend_w  = pend_w;
    next_resp_en = 1'b0;
    next_resp_d  = resp_d;
    next_mc_en   = mc_en;
    next_mc_a    = mc_a;
    fill_we      = 1'b0;

    // While a read is being drained (or prefetched) hold the first new request; a flush drops it
    if (state != IDLE && state != MISS) begin
      if (clear_branch_in) begin
        next_pend_v = 1'b0;
      end else if (if_to_icache_en_in && !pend_v) begin
        next_pend_v = 1'b1;
        next_pend_w = if_a_in[ADDR_W-1:2];
      end
    end

    case (state)
      IDLE: begin
        if (clear_branch_in) begin
          next_pend_v = 1'b0;
        end else if (lk_req) begin
          next_pend_v = 1'b0;
          if (lk_hit) begin
            next_resp_en = 1'b1;
            next_resp_d  = words[lk_idx];
          end else begin
            next_miss_w = lk_w;
            next_mc_en  = 1'b1;
            next_mc_a   = {lk_w, 2'b00};
            next_state  = MISS;
          end
        end
      end
      MISS: begin
        if (mc_to_icache_en_in) begin
          fill_we      = 1'b1;
          next_mc_en   = 1'b0;
          next_resp_en = !clear_branch_in;
          next_resp_d  = mc_d_in;
          next_state   = after_fill;
`ifdef ICACHE_PREFETCH_EN
          if (pf_need) next_miss_w = pf_w;
`endif
        end else if (clear_branch_in) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (mc_to_icache_en_in) begin
          fill_we    = 1'b1;
          next_mc_en = 1'b0;
          next_state = after_fill;
`ifdef ICACHE_PREFETCH_EN
          if (pf_need) next_miss_w = pf_w;
`endif
        end
      end
`ifdef ICACHE_PREFETCH_EN
      PREFETCH: begin
        if (!mc_en) begin
          next_mc_en = 1'b1;
          next_mc_a  = {miss_w, 2'b00};
        end else if (mc_to_icache_en_in) begin
          fill_we    = 1'b1;
          next_mc_en = 1'b0;
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Controller registers and valid bits; rdy_in low freezes everything
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      valid   <= '0;
      miss_w  <= '0;
      pend_v  <= 1'b0;
      pend_w  <= '0;
      resp_en <= 1'b0;
      resp_d  <= '0;
      mc_en   <= 1'b0;
      mc_a    <= '0;
    end else if (rdy_in) begin
      state   <= next_state;
      miss_w  <= next_miss_w;
      pend_v  <= next_pend_v;
      pend_w  <= next_pend_w;
      resp_en <= next_resp_en;
      resp_d  <= next_resp_d;
      mc_en   <= next_mc_en;
      mc_a    <= next_mc_a;
      if (fill_we) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && fill_we) begin
      tags[fill_idx]  <= fill_tag;
      words[fill_idx] <= mc_d_in;
    end
  end

  assign icache_to_if_en_out = resp_en;
  assign if_d_out            = resp_d;
  assign icache_to_mc_en_out = mc_en;
  assign icache_a_out        = mc_a;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed, table-driven bench for icache.
// Each vector is one clock: inputs are driven, the clock ticks, registered outputs are compared.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n, rdy, req, mcv, clr;
  logic [31:0] a, mcd;
  logic        if_en, mc_en;
  logic [31:0] if_d, mc_a;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        req;
    logic [31:0] a;
    logic        mcv;
    logic [31:0] mcd;
    logic        clr;
    logic        ifen;
    logic [31:0] d;
    logic        mcen;
    logic [31:0] mca;
    logic        rst_n;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];
  vec_t t;

  icache #(.INDEX_BITS(8), .ADDR_W(32)) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .rdy_in              (rdy),
    .if_to_icache_en_in  (req),
    .if_a_in             (a),
    .icache_to_if_en_out (if_en),
    .if_d_out            (if_d),
    .icache_to_mc_en_out (mc_en),
    .icache_a_out        (mc_a),
    .mc_to_icache_en_in  (mcv),
    .mc_d_in             (mcd),
    .clear_branch_in     (clr)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [31:0] ad, input logic mv,
                             input logic [31:0] md, input logic c, input logic ie,
                             input logic [31:0] dd, input logic me, input logic [31:0] ma);
    vec_t x;
    x.req = r;  x.a = ad;  x.mcv = mv; x.mcd = md; x.clr = c;
    x.ifen = ie; x.d = dd; x.mcen = me; x.mca = ma;
    x.rst_n = 1'b1; x.rdy = 1'b1;
    return x;
  endfunction

  task automatic applyStimulus(input vec_t s);
    rst_n = s.rst_n; rdy = s.rdy; req = s.req; a = s.a;
    mcv = s.mcv; mcd = s.mcd; clr = s.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t s, input string name);
    checks++;
    if (if_en !== s.ifen) begin
      failures++;
      $display("[TB] FAIL %s resp_en got=%0b want=%0b", name, if_en, s.ifen);
    end
    if (s.ifen) begin
      checks++;
      if (if_d !== s.d) begin
        failures++;
        $display("[TB] FAIL %s resp_data got=%h want=%h", name, if_d, s.d);
      end
    end
    checks++;
    if (mc_en !== s.mcen) begin
      failures++;
      $display("[TB] FAIL %s mc_en got=%0b want=%0b", name, mc_en, s.mcen);
    end
    if (s.mcen) begin
      checks++;
      if (mc_a !== s.mca) begin
        failures++;
        $display("[TB] FAIL %s mc_addr got=%h want=%h", name, mc_a, s.mca);
      end
    end
  endtask

  task automatic step(input vec_t s, input string name);
    applyStimulus(s);
    checkOutput(s, name);
  endtask

  initial begin
    // Cold miss, hit, conflict, low-bit aliasing, clear corner cases, address-space top
    tbl.push_back(v(1, 32'h0, 0, 0, 0,  0, 0, 1, 32'h0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,  0, 0, 1, 32'h0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,  0, 0, 1, 32'h0));
    tbl.push_back(v(0, 32'h0, 1, 32'h13, 0,  1, 32'h13, 0, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 0,  1, 32'h13, 0, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(v(1, 32'h400, 0, 0, 0,  0, 0, 1, 32'h400));
    tbl.push_back(v(0, 32'h0, 1, 32'h0A0A0A0A, 0,  1, 32'h0A0A0A0A, 0, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 0,  0, 0, 1, 32'h0));
    tbl.push_back(v(0, 32'h0, 1, 32'h13, 0,  1, 32'h13, 0, 0));
    tbl.push_back(v(1, 32'h3, 0, 0, 0,  1, 32'h13, 0, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 1,  0, 0, 0, 0));
    tbl.push_back(v(1, 32'h8, 0, 0, 0,  0, 0, 1, 32'h8));
    tbl.push_back(v(0, 32'h0, 1, 32'h11111111, 1,  0, 0, 0, 0));
    tbl.push_back(v(1, 32'h8, 0, 0, 0,  1, 32'h11111111, 0, 0));
    tbl.push_back(v(1, 32'hFFFFFFFE, 0, 0, 0,  0, 0, 1, 32'hFFFFFFFC));
    tbl.push_back(v(0, 32'h0, 1, 32'h22, 0,  1, 32'h22, 0, 0));
    tbl.push_back(v(1, 32'hFFFFFFFC, 0, 0, 0,  1, 32'h22, 0, 0));
    tbl.push_back(v(1, 32'h3FC, 0, 0, 0,  0, 0, 1, 32'h3FC));
    tbl.push_back(v(1, 32'h0, 0, 0, 0,  0, 0, 1, 32'h3FC));
    tbl.push_back(v(0, 32'h0, 1, 32'h33, 0,  1, 32'h33, 0, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,  0, 0, 0, 0));

    // Reset state
    rst_n = 1'b0; rdy = 1'b1; req = 1'b0; a = '0; mcv = 1'b0; mcd = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if_en, mc_en} !== 2'b00 || if_d !== 32'h0 || mc_a !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset outputs got en=%0b%0b d=%h a=%h want all zero",
               if_en, mc_en, if_d, mc_a);
    end

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));

    // Flush mid-miss with one request held and replayed after the fill
    step(v(1, 32'h100, 0, 0, 0,  0, 0, 1, 32'h100), "flush_req");
    step(v(0, 0, 0, 0, 0,  0, 0, 1, 32'h100), "flush_wait");
    step(v(0, 0, 0, 0, 1,  0, 0, 1, 32'h100), "flush_clear");
    step(v(1, 32'h100, 0, 0, 0,  0, 0, 1, 32'h100), "flush_pend");
    step(v(0, 0, 1, 32'hDEADBEEF, 0,  0, 0, 0, 0), "flush_fill");
    step(v(0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 0, 0), "flush_replay");
    step(v(0, 0, 0, 0, 0,  0, 0, 0, 0), "flush_done");

    // A second clear while draining drops the held request, yet the line is still filled
    step(v(1, 32'h500, 0, 0, 0,  0, 0, 1, 32'h500), "drop_req");
    step(v(0, 0, 0, 0, 1,  0, 0, 1, 32'h500), "drop_clear1");
    step(v(1, 32'h500, 0, 0, 0,  0, 0, 1, 32'h500), "drop_pend");
    step(v(0, 0, 0, 0, 1,  0, 0, 1, 32'h500), "drop_clear2");
    step(v(0, 0, 1, 32'h55555555, 0,  0, 0, 0, 0), "drop_fill");
    step(v(0, 0, 0, 0, 0,  0, 0, 0, 0), "drop_noreplay");
    step(v(1, 32'h500, 0, 0, 0,  1, 32'h55555555, 0, 0), "drop_hit");

    // rdy low freezes a miss, ignores a clear, and holds a response pulse
    step(v(1, 32'h600, 0, 0, 0,  0, 0, 1, 32'h600), "rdy_req");
    for (int i = 0; i < 5; i++) begin
      t = v(0, 0, 0, 0, (i == 2), 0, 0, 1, 32'h600);
      t.rdy = 1'b0;
      step(t, $sformatf("rdy_low[%0d]", i));
    end
    step(v(0, 0, 1, 32'h66, 0,  1, 32'h66, 0, 0), "rdy_fill");
    t = v(0, 0, 0, 0, 0,  1, 32'h66, 0, 0);
    t.rdy = 1'b0;
    step(t, "rdy_hold_resp");
    step(v(0, 0, 0, 0, 0,  0, 0, 0, 0), "rdy_resume");
    step(v(1, 32'h600, 0, 0, 0,  1, 32'h66, 0, 0), "rdy_hit");

    // Reset mid-miss abandons the miss and clears every valid bit
    step(v(1, 32'h700, 0, 0, 0,  0, 0, 1, 32'h700), "rstmiss_req");
    t = v(0, 0, 0, 0, 0,  0, 0, 0, 0);
    t.rst_n = 1'b0;
    step(t, "rstmiss_reset");
    step(v(1, 32'h0, 0, 0, 0,  0, 0, 1, 32'h0), "rstmiss_cold");
    step(v(0, 0, 1, 32'h13, 0,  1, 32'h13, 0, 0), "rstmiss_fill");
    step(v(0, 0, 0, 0, 0,  0, 0, 0, 0), "rstmiss_done");

    // Next-line behaviour after a demand miss at 0x200
    step(v(1, 32'h200, 0, 0, 0,  0, 0, 1, 32'h200), "pf_req");
    step(v(0, 0, 1, 32'h44, 0,  1, 32'h44, 0, 0), "pf_fill");
`ifdef ICACHE_PREFETCH_EN
    step(v(0, 0, 0, 0, 0,  0, 0, 1, 32'h204), "pf_issue");
    step(v(0, 0, 1, 32'h77, 0,  0, 0, 0, 0), "pf_pfill");
    step(v(0, 0, 0, 0, 0,  0, 0, 0, 0), "pf_idle");
    step(v(1, 32'h204, 0, 0, 0,  1, 32'h77, 0, 0), "pf_hit");
`else
    step(v(0, 0, 0, 0, 0,  0, 0, 0, 0), "pf_idle");
    step(v(1, 32'h204, 0, 0, 0,  0, 0, 1, 32'h204), "pf_miss");
    step(v(0, 0, 1, 32'h77, 0,  1, 32'h77, 0, 0), "pf_fill2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
